// File: rtl/uart_bus_master_pkg.sv
// Shared types and protocol constants for the UART-driven bus initiator.
package uart_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    localparam int unsigned TMO_W = 32;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_bus_master_word_serializer.sv
// Sends a loaded word as 1 or 4 bytes, LSB first, over a valid/ready byte handshake.
module word_serializer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_len4,
    input  logic [31:0] i_word,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [23:0] r_rest;
    logic [1:0]  r_left;
    logic        w_accept;

    assign w_accept = o_tx_valid && i_tx_ready;
    // done pulses in the acceptance cycle so the parser can take a new byte right after
    assign o_done   = w_accept && (r_left == 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            r_rest     <= 24'h0;
            r_left     <= 2'd0;
        end else if (i_load) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= i_word[7:0];
            r_rest     <= i_word[31:8];
            r_left     <= i_len4 ? 2'd3 : 2'd0;
        end else if (w_accept) begin
            if (r_left == 2'd0) begin
                o_tx_valid <= 1'b0;
            end else begin
                o_tx_data <= r_rest[7:0];
                r_rest    <= {8'h00, r_rest[23:8]};
                r_left    <= r_left - 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Byte-stream command parser that issues single-word bus reads/writes and
// returns an ack or the read data as bytes.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic             r_is_write;
    logic [TMO_W-1:0] r_tmo;

    logic             w_tmo_hit;
    logic             w_ser_load;
    logic             w_ser_len4;
    logic [31:0]      w_ser_word;
    logic             w_ser_done;

    // r_tmo holds the idle cycles still allowed before the current command is abandoned
    assign w_tmo_hit = (C_TIMEOUT != 0) && (r_tmo == '0);

    always_comb begin
        w_ser_load = 1'b0;
        w_ser_len4 = 1'b0;
        w_ser_word = {24'h0, RSP_ERR};
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid && !is_cmd(i_rx_data)) begin
                    w_ser_load = 1'b1;
                end
            end
            ST_BUS: begin
                if (i_mem_ready) begin
                    w_ser_load = 1'b1;
                    if (r_is_write) begin
                        w_ser_word = {24'h0, RSP_ACK};
                    end else begin
                        w_ser_word = i_mem_rdata;
                        w_ser_len4 = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_is_write  <= 1'b0;
            r_tmo       <= '0;
            o_mem_addr  <= 32'h0;
            o_mem_wdata <= 32'h0;
            o_mem_wstrb <= 4'h0;
            o_mem_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (is_cmd(i_rx_data)) begin
                            r_state    <= ST_ADDR;
                            r_is_write <= (i_rx_data == CMD_WRITE);
                            r_cnt      <= 2'd0;
                            r_tmo      <= TMO_W'(C_TIMEOUT);
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (i_rx_valid) begin
                        r_tmo <= TMO_W'(C_TIMEOUT);
                        r_cnt <= r_cnt + 2'd1;
                        if (r_state == ST_ADDR) begin
                            o_mem_addr[{r_cnt, 3'b000} +: 8] <= i_rx_data;
                        end else begin
                            o_mem_wdata[{r_cnt, 3'b000} +: 8] <= i_rx_data;
                        end
                        if (r_cnt == 2'd3) begin
                            if (r_state == ST_ADDR && r_is_write) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state     <= ST_BUS;
                                o_mem_valid <= 1'b1;
                                o_mem_wstrb <= r_is_write ? 4'hF : 4'h0;
                            end
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= ST_IDLE;
                    end else if (r_tmo != '0) begin
                        r_tmo <= r_tmo - 1'b1;
                    end
                end
                ST_BUS: begin
                    if (i_mem_ready) begin
                        o_mem_valid <= 1'b0;
                        o_mem_wstrb <= 4'h0;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_ser_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    word_serializer u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_ser_load),
        .i_len4     (w_ser_len4),
        .i_word     (w_ser_word),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (w_ser_done)
    );

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench: stimulus pushes expected bus cycles and tx bytes, monitors pop and compare.
module tb_uart_bus_master;

    localparam int TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] i_mem_rdata;

    always #5 i_clk = ~i_clk;

    uart_bus_master #(.C_TIMEOUT(TMO)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wstrb (o_mem_wstrb),
        .o_mem_valid (o_mem_valid),
        .i_mem_ready (i_mem_ready),
        .i_mem_rdata (i_mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wd;
        int          delay;
    } bus_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } resp_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    resp_t       resp_q[$];

    int total = 0;
    int bad   = 0;
    int tx_mode = 0;   // 0: ready always, 1: toggling, 2: random
    bit inject = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // bus responder: ready after 'delay' cycles of mem_valid, giving delay+1 cycles high
    initial begin
        resp_t r;
        int    n;
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            i_mem_ready = 1'b0;
            i_mem_rdata = $urandom;
            if (o_mem_valid) begin
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else begin r.delay = 0; r.rdata = $urandom; end
                n = 0;
                while (n < r.delay && o_mem_valid) begin
                    @(negedge i_clk);
                    n++;
                end
                if (o_mem_valid) begin
                    i_mem_ready = 1'b1;
                    i_mem_rdata = r.rdata;
                end
            end
        end
    end

    // bus monitor
    initial begin
        bus_t        cur;
        logic [31:0] cap_addr, cap_wdata;
        logic [3:0]  cap_wstrb;
        int          hi = 0;
        bit          in_txn = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_mem_valid) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    hi        = 0;
                    cap_addr  = o_mem_addr;
                    cap_wdata = o_mem_wdata;
                    cap_wstrb = o_mem_wstrb;
                    if (exp_bus.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_bus: got addr %h wstrb %h expected no bus cycle", o_mem_addr, o_mem_wstrb);
                        cur.delay = -1;
                    end else begin
                        cur = exp_bus.pop_front();
                        check("bus_addr", o_mem_addr, cur.addr);
                        check("bus_wstrb", {28'h0, o_mem_wstrb}, {28'h0, cur.wstrb});
                        if (cur.chk_wd) check("bus_wdata", o_mem_wdata, cur.wdata);
                    end
                end else begin
                    check("addr_stable", o_mem_addr, cap_addr);
                    check("wdata_stable", o_mem_wdata, cap_wdata);
                    check("wstrb_stable", {28'h0, o_mem_wstrb}, {28'h0, cap_wstrb});
                end
                hi++;
            end else begin
                check("wstrb_idle", {28'h0, o_mem_wstrb}, 32'h0);
                if (in_txn) begin
                    in_txn = 1'b0;
                    if (cur.delay >= 0 && cur.delay < 1000) check("bus_len", hi, cur.delay + 1);
                end
            end
        end
    end

    // tx monitor; also drives tx_ready so decision and check see the same value
    initial begin
        logic [7:0] held = 8'h0;
        bit         stalled = 1'b0;
        i_tx_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            case (tx_mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = !i_tx_ready;
                default: i_tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (o_tx_valid) begin
                if (stalled) check("tx_hold", {24'h0, o_tx_data}, {24'h0, held});
                if (i_tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_tx: got %h expected no byte", o_tx_data);
                    end else begin
                        check("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_tx.pop_front()});
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = o_tx_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0 || o_mem_valid || o_tx_valid) && n < 400) begin
            if (inject && (o_mem_valid || o_tx_valid) && $urandom_range(0, 1) == 1) begin
                i_rx_valid = 1'b1;
                i_rx_data  = 8'($urandom);
            end else begin
                i_rx_valid = 1'b0;
            end
            @(negedge i_clk);
            n++;
        end
        i_rx_valid = 1'b0;
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL completion_timeout: got %0d pending tx, %0d pending bus, expected none", exp_tx.size(), exp_bus.size());
        end
        repeat (2) @(negedge i_clk);
    endtask

    // reference model: command bytes in, one bus cycle and a response byte list out
    task automatic send_cmd(input bit is_w, input logic [31:0] addr, input logic [31:0] data,
                            input int delay, input logic [31:0] rdata, input int gap_max);
        logic [7:0] b[$];
        bus_t       e;
        resp_t      r;
        b.push_back(is_w ? 8'h57 : 8'h52);
        for (int k = 0; k < 4; k++) b.push_back(addr[8*k +: 8]);
        if (is_w) for (int k = 0; k < 4; k++) b.push_back(data[8*k +: 8]);
        e.addr = addr; e.wdata = data; e.wstrb = is_w ? 4'hF : 4'h0; e.chk_wd = is_w; e.delay = delay;
        exp_bus.push_back(e);
        r.delay = delay; r.rdata = rdata;
        resp_q.push_back(r);
        if (is_w) exp_tx.push_back(8'h4B);
        else for (int k = 0; k < 4; k++) exp_tx.push_back(rdata[8*k +: 8]);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i]);
            if (i != b.size() - 1) repeat ($urandom_range(0, gap_max)) @(negedge i_clk);
        end
        check("valid_latency", {31'h0, o_mem_valid}, 32'h1);
        wait_done();
    endtask

    task automatic send_bad(input logic [7:0] b);
        exp_tx.push_back(8'h3F);
        send_byte(b);
        check("err_latency", {31'h0, o_tx_valid}, 32'h1);
        check("err_no_bus", {31'h0, o_mem_valid}, 32'h0);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bb;
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (3) @(negedge i_clk);
        check("rst_mem_valid", {31'h0, o_mem_valid}, 32'h0);
        check("rst_mem_wstrb", {28'h0, o_mem_wstrb}, 32'h0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_mem_wdata", o_mem_wdata, 32'h0);
        check("rst_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
        i_reset = 1'b0;
        @(negedge i_clk);

        tx_mode = 0;
        send_cmd(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 1, 32'h0, 0);

        tx_mode = 1;
        send_cmd(1'b0, 32'h2000_0004, 32'h0, 3, 32'h1234_5678, 0);

        tx_mode = 2;
        send_bad(8'h41);
        send_cmd(1'b1, 32'h0000_0040, 32'h0102_0304, 0, 32'h0, 2);

        // abandoned command: 20 idle cycles exceed the 16 allowed
        tx_mode = 0;
        send_byte(8'h57);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (20) @(negedge i_clk);
        check("tmo_no_bus", {31'h0, o_mem_valid}, 32'h0);
        check("tmo_no_tx", {31'h0, o_tx_valid}, 32'h0);
        send_cmd(1'b0, 32'hCAFE_0010, 32'h0, 2, 32'hA5A5_5A5A, 1);

        // reset while the responder never answers
        exp_bus.push_back('{addr: 32'h0BAD_0000, wdata: 32'h0, wstrb: 4'h0, chk_wd: 1'b0, delay: 1000});
        resp_q.push_back('{delay: 1000, rdata: 32'h0});
        send_byte(8'h52);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'hAD); send_byte(8'h0B);
        repeat (4) @(negedge i_clk);
        check("bus_waiting", {31'h0, o_mem_valid}, 32'h1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("rst_mid_valid", {31'h0, o_mem_valid}, 32'h0);
        check("rst_mid_tx", {31'h0, o_tx_valid}, 32'h0);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        check("rst_no_resp", {31'h0, o_tx_valid}, 32'h0);
        send_bad(8'h00);

        // strobes during BUS/RESP must be dropped
        inject  = 1'b1;
        tx_mode = 1;
        send_cmd(1'b0, 32'h3000_0008, 32'h0, 2, 32'h8765_4321, 0);
        send_cmd(1'b1, 32'h3000_000C, 32'h5555_AAAA, 1, 32'h0, 0);
        send_bad(8'hFF);

        for (int t = 0; t < 25; t++) begin
            tx_mode = $urandom_range(0, 2);
            inject  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: send_cmd(1'b1, $urandom, $urandom, $urandom_range(0, 4), 32'h0, 3);
                1: send_cmd(1'b0, $urandom, 32'h0, $urandom_range(0, 4), $urandom, 3);
                default: begin
                    bb = 8'($urandom);
                    while (bb == 8'h57 || bb == 8'h52) bb = 8'($urandom);
                    send_bad(bb);
                end
            endcase
        end

        repeat (5) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
